adder_result_checker: RTL and testbench

- Downstream stage of the 4-bit simple adder.
- Consumes (a, b, sum) triples from the adder datapath over a valid/ready handshake and checks each sum against the modular reference a+b.
- Counts passes, fails, unsigned carries and signed overflows over a programmed number of samples, then presents a held report over a second valid/ready handshake.
- Used as the self-checking back end of adder regressions.

---
 rtl/adder_result_checker.sv | 153 +++++++++++++++
 tb/tb_adder_result_checker.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_checker.sv
// Back end of the adder regression: checks (a, b, sum) triples against a+b,
// accumulates pass/fail/carry/overflow statistics and hands out a held report.
module adder_result_checker #(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_samples,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [DATA_W-1:0] in_sum,
   output logic              busy,
   output logic              rpt_valid,
   input  logic              rpt_ready,
   output logic [CNT_W-1:0]  rpt_pass_cnt,
   output logic [CNT_W-1:0]  rpt_fail_cnt,
   output logic [CNT_W-1:0]  rpt_carry_cnt,
   output logic [CNT_W-1:0]  rpt_sovf_cnt,
   output logic              rpt_first_fail_valid,
   output logic [CNT_W-1:0]  rpt_first_fail_idx
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      REPORT  = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [CNT_W-1:0]  count_r;
   logic [CNT_W-1:0]  idx_r;
   logic [DATA_W:0]   full_s;
   logic [DATA_W-1:0] expected_s;
   logic              carry_s;
   logic              sovf_s;
   logic              match_s;
   logic              accept_s;
   logic              last_s;
   logic              launch_s;

   // Two's-complement overflow: like-signed operands yielding an opposite-signed result.
   function automatic logic calc_sovf(input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b,
                                      input logic [DATA_W-1:0] s);
      return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
   endfunction

   // Reference sum and per-sample flags.
   always_comb begin
      full_s     = {1'b0, in_a} + {1'b0, in_b};
      expected_s = full_s[DATA_W-1:0];
      carry_s    = full_s[DATA_W];
      sovf_s     = calc_sovf(in_a, in_b, expected_s);
      match_s    = (in_sum == expected_s);
      accept_s   = (state_r == COLLECT) && in_valid;
      last_s     = (idx_r == (count_r - CNT_W'(1)));
      launch_s   = (state_r == IDLE) && start;
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (num_samples != {CNT_W{1'b0}}) begin
                  state_nxt_s = COLLECT;
               end else begin
                  state_nxt_s = REPORT;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         COLLECT: begin
            if (accept_s && last_s) begin
               state_nxt_s = REPORT;
            end else begin
               state_nxt_s = COLLECT;
            end
         end
         REPORT: begin
            if (rpt_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = REPORT;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register; handshake outputs are registered from the next state so they track it exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         rpt_valid <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         in_ready  <= (state_nxt_s == COLLECT);
         busy      <= (state_nxt_s != IDLE);
         rpt_valid <= (state_nxt_s == REPORT);
      end
   end

   // Run bookkeeping and statistics; report fields stay held until the next launch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r              <= {CNT_W{1'b0}};
         idx_r                <= {CNT_W{1'b0}};
         rpt_pass_cnt         <= {CNT_W{1'b0}};
         rpt_fail_cnt         <= {CNT_W{1'b0}};
         rpt_carry_cnt        <= {CNT_W{1'b0}};
         rpt_sovf_cnt         <= {CNT_W{1'b0}};
         rpt_first_fail_valid <= 1'b0;
         rpt_first_fail_idx   <= {CNT_W{1'b0}};
      end else if (launch_s) begin
         count_r              <= num_samples;
         idx_r                <= {CNT_W{1'b0}};
         rpt_pass_cnt         <= {CNT_W{1'b0}};
         rpt_fail_cnt         <= {CNT_W{1'b0}};
         rpt_carry_cnt        <= {CNT_W{1'b0}};
         rpt_sovf_cnt         <= {CNT_W{1'b0}};
         rpt_first_fail_valid <= 1'b0;
         rpt_first_fail_idx   <= {CNT_W{1'b0}};
      end else if (accept_s) begin
         idx_r <= idx_r + CNT_W'(1);
         if (match_s) begin
            rpt_pass_cnt <= rpt_pass_cnt + CNT_W'(1);
         end else begin
            rpt_fail_cnt <= rpt_fail_cnt + CNT_W'(1);
            if (!rpt_first_fail_valid) begin
               rpt_first_fail_valid <= 1'b1;
               rpt_first_fail_idx   <= idx_r;
            end
         end
         if (carry_s) begin
            rpt_carry_cnt <= rpt_carry_cnt + CNT_W'(1);
         end
         if (sovf_s) begin
            rpt_sovf_cnt <= rpt_sovf_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_adder_result_checker.sv
// Scoreboard bench for adder_result_checker: a behavioural model pushes the expected
// report for each run, and it is popped and compared when the DUT raises rpt_valid.
module tb_adder_result_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] num_samples;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_a;
   logic [3:0] in_b;
   logic [3:0] in_sum;
   logic       busy;
   logic       rpt_valid;
   logic       rpt_ready;
   logic [7:0] rpt_pass_cnt;
   logic [7:0] rpt_fail_cnt;
   logic [7:0] rpt_carry_cnt;
   logic [7:0] rpt_sovf_cnt;
   logic       rpt_first_fail_valid;
   logic [7:0] rpt_first_fail_idx;

   typedef struct {
      int pass_c;
      int fail_c;
      int carry_c;
      int sovf_c;
      int ffv;
      int ffi;
   } rpt_t;

   rpt_t sb_q[$];
   rpt_t last_rpt;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   m_pass, m_fail, m_carry, m_sovf, m_ffv, m_ffi, m_idx;

   adder_result_checker #(.DATA_W(4), .CNT_W(8)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .start                (start),
      .num_samples          (num_samples),
      .in_valid             (in_valid),
      .in_ready             (in_ready),
      .in_a                 (in_a),
      .in_b                 (in_b),
      .in_sum               (in_sum),
      .busy                 (busy),
      .rpt_valid            (rpt_valid),
      .rpt_ready            (rpt_ready),
      .rpt_pass_cnt         (rpt_pass_cnt),
      .rpt_fail_cnt         (rpt_fail_cnt),
      .rpt_carry_cnt        (rpt_carry_cnt),
      .rpt_sovf_cnt         (rpt_sovf_cnt),
      .rpt_first_fail_valid (rpt_first_fail_valid),
      .rpt_first_fail_idx   (rpt_first_fail_idx)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic rpt_t model_snapshot();
      rpt_t r;
      r.pass_c  = m_pass;
      r.fail_c  = m_fail;
      r.carry_c = m_carry;
      r.sovf_c  = m_sovf;
      r.ffv     = m_ffv;
      r.ffi     = m_ffi;
      return r;
   endfunction

   task automatic begin_run(input int n);
      m_pass = 0; m_fail = 0; m_carry = 0; m_sovf = 0; m_ffv = 0; m_ffi = 0; m_idx = 0;
      @(posedge clk); #1;
      start       = 1'b1;
      num_samples = n[7:0];
      @(posedge clk); #1;
      start       = 1'b0;
      num_samples = 8'hAA;
      if (n == 0) sb_q.push_back(model_snapshot());
   endtask

   task automatic send(input int a, input int b, input int s, input bit last);
      int full, sa, sb, ssum, k;
      full = a + b;
      sa   = (a > 7) ? a - 16 : a;
      sb   = (b > 7) ? b - 16 : b;
      ssum = sa + sb;
      if (s == (full % 16)) begin
         m_pass++;
      end else begin
         m_fail++;
         if (m_ffv == 0) begin
            m_ffv = 1;
            m_ffi = m_idx;
         end
      end
      if (full > 15) m_carry++;
      if (ssum > 7 || ssum < -8) m_sovf++;
      m_idx++;
      in_a = a[3:0]; in_b = b[3:0]; in_sum = s[3:0]; in_valid = 1'b1;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) check_val("accept_timeout", 32'd0, 32'd1);
      check_val("rpt_valid_before_accept", rpt_valid, 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (last) begin
         sb_q.push_back(model_snapshot());
         check_val("rpt_valid_zero_latency", rpt_valid, 32'd1);
      end
   endtask

   task automatic gap();
      in_a = 4'($urandom_range(0, 15)); in_b = 4'($urandom_range(0, 15));
      in_sum = 4'($urandom_range(0, 15)); in_valid = 1'b0;
      @(negedge clk);
      check_val("in_ready_during_gap", in_ready, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic check_report();
      rpt_t r;
      int   k;
      k = 0;
      @(negedge clk);
      while (!rpt_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!rpt_valid) check_val("report_timeout", 32'd0, 32'd1);
      if (sb_q.size() == 0) begin
         check_val("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         r = sb_q.pop_front();
         last_rpt = r;
         check_val("pass_cnt",         rpt_pass_cnt,         r.pass_c);
         check_val("fail_cnt",         rpt_fail_cnt,         r.fail_c);
         check_val("carry_cnt",        rpt_carry_cnt,        r.carry_c);
         check_val("sovf_cnt",         rpt_sovf_cnt,         r.sovf_c);
         check_val("first_fail_valid", rpt_first_fail_valid, r.ffv);
         if (r.ffv != 0) check_val("first_fail_idx", rpt_first_fail_idx, r.ffi);
         check_val("in_ready_in_report", in_ready, 32'd0);
         check_val("busy_in_report",     busy,     32'd1);
      end
   endtask

   task automatic release_report();
      @(posedge clk); #1;
      rpt_ready = 1'b1;
      @(posedge clk); #1;
      rpt_ready = 1'b0;
      check_val("busy_after_release",      busy,      32'd0);
      check_val("rpt_valid_after_release", rpt_valid, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; start = 1'b0; num_samples = 8'd0; in_valid = 1'b0;
      in_a = 4'd0; in_b = 4'd0; in_sum = 4'd0; rpt_ready = 1'b0;
      #1;
      check_val("reset_in_ready",  in_ready,     32'd0);
      check_val("reset_busy",      busy,         32'd0);
      check_val("reset_rpt_valid", rpt_valid,    32'd0);
      check_val("reset_pass_cnt",  rpt_pass_cnt, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Basic run
      begin_run(2);
      send(7, 2, 9, 1'b0);
      send(3, 4, 7, 1'b1);
      check_report();
      release_report();

      // Fail and overflow, followed by report backpressure
      begin_run(3);
      send(15, 1, 0, 1'b0);
      send(8, 8, 0, 1'b0);
      send(5, 5, 9, 1'b1);
      check_report();
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         start       = (i == 2);
         num_samples = 8'd3;
         @(negedge clk);
         check_val("hold_rpt_valid", rpt_valid,    32'd1);
         check_val("hold_in_ready",  in_ready,     32'd0);
         check_val("hold_pass_cnt",  rpt_pass_cnt, last_rpt.pass_c);
         check_val("hold_fail_idx",  rpt_first_fail_idx, last_rpt.ffi);
      end
      start = 1'b0;
      release_report();
      check_val("retain_fail_cnt", rpt_fail_cnt,  last_rpt.fail_c);
      check_val("retain_carry",    rpt_carry_cnt, last_rpt.carry_c);

      // Zero-length run
      begin_run(0);
      check_val("zero_run_rpt_valid", rpt_valid, 32'd1);
      check_val("zero_run_in_ready",  in_ready,  32'd0);
      check_report();
      release_report();

      // Input gaps: valid pattern 1,0,0,1,1,0,1
      begin_run(4);
      send(9, 9, 2, 1'b0);
      gap();
      gap();
      send(4, 4, 8, 1'b0);
      send(6, 12, 3, 1'b0);
      gap();
      send(1, 2, 3, 1'b1);
      check_report();
      release_report();

      // Randomised run with injected faults
      begin_run(20);
      for (int i = 0; i < 20; i++) begin
         int a, b, s;
         a = $urandom_range(0, 15);
         b = $urandom_range(0, 15);
         s = ($urandom_range(0, 3) == 0) ? (a + b + 1) % 16 : (a + b) % 16;
         send(a, b, s, (i == 19));
      end
      check_report();
      release_report();

      // Asynchronous reset mid-collect
      begin_run(4);
      send(15, 15, 14, 1'b0);
      send(7, 7, 14, 1'b0);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check_val("async_in_ready",  in_ready,      32'd0);
      check_val("async_busy",      busy,          32'd0);
      check_val("async_rpt_valid", rpt_valid,     32'd0);
      check_val("async_pass_cnt",  rpt_pass_cnt,  32'd0);
      check_val("async_carry_cnt", rpt_carry_cnt, 32'd0);
      check_val("async_sovf_cnt",  rpt_sovf_cnt,  32'd0);
      @(negedge clk);
      rst = 1'b0;
      begin_run(2);
      send(8, 8, 1, 1'b0);
      send(2, 3, 5, 1'b1);
      check_report();
      release_report();

      check_val("scoreboard_drained", sb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
